// File: rtl/pipeline_controller_pkg.sv
// Shared types and defaults for the in-order pipeline stall/flush controller.
package pipeline_controller_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam int DEF_MEM_TIMEOUT = 15;
  localparam int DEF_CNT_W       = 16;
  localparam int REG_IDX_W       = 5;

endpackage

// File: rtl/pipeline_controller_load_use.sv
// Load-use hazard: a load in ID/EX writes a register the IF/ID instruction reads.
import pipeline_controller_pkg::*;

module load_use_detect (
  input  logic                 idex_memread,
  input  logic [REG_IDX_W-1:0] idex_rd,
  input  logic [REG_IDX_W-1:0] ifid_rs1,
  input  logic [REG_IDX_W-1:0] ifid_rs2,
  output logic                 hazard
);

  // x0 is hardwired, so a load into it never creates a dependency
  assign hazard = idex_memread && (idex_rd != '0) &&
                  ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline register enable/flush control: load-use stalls, redirect flushes,
// memory wait freezes with a timeout into a sticky error state.
import pipeline_controller_pkg::*;

module pipeline_controller #(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 idex_memread,
  input  logic [REG_IDX_W-1:0] idex_rd,
  input  logic [REG_IDX_W-1:0] ifid_rs1,
  input  logic [REG_IDX_W-1:0] ifid_rs2,
  input  logic                 redirect,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_enable,
  output logic                 ifid_enable,
  output logic                 idex_enable,
  output logic                 exmem_enable,
  output logic                 memwb_enable,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 mem_error,
  output logic [CNT_W-1:0]     stall_count
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_e          r_state;
  logic [TW-1:0]   r_timer;
  logic [CNT_W-1:0] r_stall_cnt;

  state_e          w_next;
  logic            w_hazard;
  logic            w_mem_block;
  logic [TW-1:0]   w_wait_cnt;

  load_use_detect u_lud (
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .ifid_rs1     (ifid_rs1),
    .ifid_rs2     (ifid_rs2),
    .hazard       (w_hazard)
  );

  assign w_mem_block = mem_req && !mem_ready;
  // Blocked cycles already spent before this one; RUN starts a fresh count
  assign w_wait_cnt  = (r_state == RUN) ? '0 : r_timer;

  always_comb begin
    w_next       = r_state;
    pc_enable    = 1'b0;
    ifid_enable  = 1'b0;
    idex_enable  = 1'b0;
    exmem_enable = 1'b0;
    memwb_enable = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    mem_error    = 1'b0;
    case (r_state)
      RUN, MEM_WAIT: begin
        if (w_mem_block) begin
          w_next = (w_wait_cnt == TW'(MEM_TIMEOUT - 1)) ? ERROR : MEM_WAIT;
        end else if (redirect) begin
          w_next       = RUN;
          pc_enable    = 1'b1;
          ifid_enable  = 1'b1;
          idex_enable  = 1'b1;
          exmem_enable = 1'b1;
          memwb_enable = 1'b1;
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
        end else if (w_hazard) begin
          w_next       = RUN;
          idex_enable  = 1'b1;
          idex_flush   = 1'b1;
          exmem_enable = 1'b1;
          memwb_enable = 1'b1;
        end else begin
          w_next       = RUN;
          pc_enable    = 1'b1;
          ifid_enable  = 1'b1;
          idex_enable  = 1'b1;
          exmem_enable = 1'b1;
          memwb_enable = 1'b1;
        end
      end
      ERROR: begin
        w_next    = ERROR;
        mem_error = 1'b1;
      end
      default: w_next = RUN;
    endcase
    if (reset) begin
      pc_enable    = 1'b0;
      ifid_enable  = 1'b0;
      idex_enable  = 1'b0;
      exmem_enable = 1'b0;
      memwb_enable = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      mem_error    = 1'b0;
    end
  end

  // Timer holds the number of blocked cycles including the one just taken,
  // so the MEM_TIMEOUT-th consecutive blocked edge lands in ERROR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == MEM_WAIT) begin
        if (w_wait_cnt != '1) r_timer <= w_wait_cnt + TW'(1);
      end else if (w_next == RUN) begin
        r_timer <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     r_stall_cnt <= '0;
    else if (!pc_enable && (r_stall_cnt != '1))    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller; a CNT_W=4 copy shares the stimulus.
import pipeline_controller_pkg::*;

module tb_pipeline_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       idex_memread;
  logic [4:0] idex_rd, ifid_rs1, ifid_rs2;
  logic       redirect, mem_req, mem_ready;

  logic        pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable;
  logic        ifid_flush, idex_flush, mem_error;
  logic [15:0] stall_count;

  logic        s_pc_enable, s_ifid_enable, s_idex_enable, s_exmem_enable, s_memwb_enable;
  logic        s_ifid_flush, s_idex_flush, s_mem_error;
  logic [3:0]  s_stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_controller dut (
    .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .redirect(redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_enable(pc_enable),
    .ifid_enable(ifid_enable), .idex_enable(idex_enable),
    .exmem_enable(exmem_enable), .memwb_enable(memwb_enable),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mem_error(mem_error), .stall_count(stall_count)
  );

  pipeline_controller #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .redirect(redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_enable(s_pc_enable),
    .ifid_enable(s_ifid_enable), .idex_enable(s_idex_enable),
    .exmem_enable(s_exmem_enable), .memwb_enable(s_memwb_enable),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .mem_error(s_mem_error), .stall_count(s_stall_count)
  );

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
  logic [6:0] ctl;
  assign ctl = {pc_enable, ifid_enable, idex_enable, exmem_enable,
                memwb_enable, ifid_flush, idex_flush};

  localparam logic [6:0] C_ZERO = 7'b0000000;
  localparam logic [6:0] C_RUN  = 7'b1111100;
  localparam logic [6:0] C_HAZ  = 7'b0011101;
  localparam logic [6:0] C_RDIR = 7'b1111111;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    idex_memread = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
    redirect = 0; mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    // Reset with busy inputs: outputs must still be all zero
    reset = 1; idle_inputs();
    mem_req = 1; redirect = 1;
    tick(); tick();
    chk("rst_ctl", 32'(ctl), 32'(C_ZERO));
    chk("rst_err", 32'(mem_error), 0);
    chk("rst_cnt", 32'(stall_count), 0);
    chk("rst_state", 32'(dut.r_state), 32'(RUN));
    idle_inputs();
    reset = 0; #1;
    chk("idle_ctl", 32'(ctl), 32'(C_RUN));
    tick();
    chk("idle_cnt", 32'(stall_count), 0);

    // Load-use hazard on rs2
    idex_memread = 1; idex_rd = 5; ifid_rs1 = 3; ifid_rs2 = 5; #1;
    chk("haz_ctl", 32'(ctl), 32'(C_HAZ));
    tick();
    chk("haz_cnt", 32'(stall_count), 1);
    idle_inputs(); #1;
    chk("haz_clear", 32'(ctl), 32'(C_RUN));

    // Redirect beats hazard
    idex_memread = 1; idex_rd = 5; ifid_rs2 = 5; redirect = 1; #1;
    chk("rdir_ctl", 32'(ctl), 32'(C_RDIR));
    tick();
    chk("rdir_cnt", 32'(stall_count), 1);

    // x0 destination never stalls
    idle_inputs(); idex_memread = 1; idex_rd = 0; ifid_rs1 = 0; #1;
    chk("x0_ctl", 32'(ctl), 32'(C_RUN));
    tick();
    chk("x0_cnt", 32'(stall_count), 1);

    // Three blocked cycles then ready
    idle_inputs(); mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("memw_ctl%0d", i), 32'(ctl), 32'(C_ZERO));
      tick();
    end
    chk("memw_state", 32'(dut.r_state), 32'(MEM_WAIT));
    mem_ready = 1; #1;
    chk("memw_rel_ctl", 32'(ctl), 32'(C_RUN));
    tick();
    chk("memw_rel_state", 32'(dut.r_state), 32'(RUN));
    chk("memw_cnt", 32'(stall_count), 4);

    // Request and ready together from RUN: no stall
    mem_req = 1; mem_ready = 1; #1;
    chk("same_cyc_ctl", 32'(ctl), 32'(C_RUN));
    tick();
    chk("same_cyc_cnt", 32'(stall_count), 4);

    // Timeout: 15 consecutive blocked edges -> ERROR
    mem_ready = 0;
    for (int i = 0; i < 14; i++) tick();
    chk("to_14_state", 32'(dut.r_state), 32'(MEM_WAIT));
    chk("to_14_err", 32'(mem_error), 0);
    tick();
    chk("to_15_state", 32'(dut.r_state), 32'(ERROR));
    chk("to_15_err", 32'(mem_error), 1);
    chk("to_15_ctl", 32'(ctl), 32'(C_ZERO));
    idle_inputs(); tick();
    chk("err_sticky", 32'(mem_error), 1);
    chk("err_ctl", 32'(ctl), 32'(C_ZERO));
    chk("err_cnt", 32'(stall_count), 20);

    // Reset out of ERROR
    reset = 1; #1;
    chk("err_rst_ctl", 32'(ctl), 32'(C_ZERO));
    chk("err_rst_err", 32'(mem_error), 0);
    chk("err_rst_cnt", 32'(stall_count), 0);
    chk("err_rst_state", 32'(dut.r_state), 32'(RUN));
    tick(); reset = 0; #1;

    // Reset mid MEM_WAIT leaves no residual timer
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_timer", 32'(dut.r_timer), 5);
    reset = 1; #1;
    chk("mid_rst_timer", 32'(dut.r_timer), 0);
    chk("mid_rst_state", 32'(dut.r_state), 32'(RUN));
    tick(); idle_inputs(); reset = 0; #1;

    // 20 hazard stalls: 16-bit counts on, 4-bit saturates at 15
    idex_memread = 1; idex_rd = 7; ifid_rs1 = 7;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", 32'(s_stall_count), 14);
    tick();
    chk("sat_15", 32'(s_stall_count), 15);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_20", 32'(s_stall_count), 15);
    chk("wide_20", 32'(stall_count), 20);
    idle_inputs(); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum consecutive MEM_WAIT cycles before error.
REQ-002 SHALL have parameter CNT_W, default 16: stall counter width.
REQ-003 SHALL have ports in this order:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- idex_memread  in  1  instruction in ID/EX is a load.
- idex_rd  in  5  destination register in ID/EX.
- ifid_rs1  in  5  source register 1 in IF/ID.
- ifid_rs2  in  5  source register 2 in IF/ID.
- redirect  in  1  taken branch or jal resolved in EX.
- mem_req  in  1  MEM stage has MemRead or MemWrite.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_enable  out  1  PC load.
- ifid_enable, idex_enable, exmem_enable, memwb_enable  out  1 each  pipeline register enables.
- ifid_flush, idex_flush  out  1 each  load bubble (initvalue) into the register.
- mem_error  out  1  sticky memory timeout flag.
- stall_count  out  CNT_W  total stalled cycles.

Function
REQ-004 SHALL implement FSM states RUN, MEM_WAIT and ERROR.
REQ-005 SHALL define hazard = idex_memread && idex_rd!=0 && (idex_rd==ifid_rs1 || idex_rd==ifid_rs2).
REQ-006 SHALL define mem_block = mem_req && !mem_ready.
REQ-007 SHALL generate the control outputs combinationally from the current state and inputs.
REQ-008 In RUN or MEM_WAIT with mem_block=1: all enables SHALL be 0 and all flushes 0 (freeze); next state MEM_WAIT.
REQ-009 In RUN or MEM_WAIT with mem_block=0 and redirect=1: all enables SHALL be 1, ifid_flush=1 and idex_flush=1; next state RUN.
- Redirect SHALL take priority over hazard.
REQ-010 In RUN or MEM_WAIT with mem_block=0, redirect=0 and hazard=1: pc_enable=0, ifid_enable=0, idex_enable=1, idex_flush=1, exmem_enable=1, memwb_enable=1; next state RUN.
REQ-011 Otherwise in RUN or MEM_WAIT: all enables SHALL be 1 and flushes 0; next state RUN.
REQ-012 The wait timer SHALL clear on every transition into MEM_WAIT from RUN.
- It SHALL increment on each cycle spent in MEM_WAIT with mem_block=1.
- When mem_block=1 with timer==MEM_TIMEOUT-1, next state SHALL be ERROR instead of MEM_WAIT.
REQ-013 ERROR: all enables SHALL be 0 and all flushes 0; mem_error=1; exit only by reset.
REQ-014 stall_count SHALL increment by 1 on each rising edge where pc_enable==0, including ERROR cycles.
- It SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-015 The timer SHALL be $clog2(MEM_TIMEOUT+1) bits wide and SHALL NOT wrap.
REQ-016 Simultaneous mem_req and mem_ready on the first cycle SHALL cause no stall.

Reset
REQ-017 While reset=1, regardless of clk:
- state=RUN, timer=0, stall_count=0, mem_error=0;
- all enables=0, all flushes=0.
REQ-018 After reset deasserts, the first rising edge SHALL evaluate from RUN.
REQ-019 Reset asserted mid MEM_WAIT or in ERROR SHALL abort to RUN with no residual timer value.

Structure
REQ-020 A shared package SHALL hold:
- the FSM state enumeration (2-bit);
- default MEM_TIMEOUT and CNT_W constants;
- the register-index width (5).
REQ-021 Hazard comparison SHALL be a sub-module load_use_detect (pure combinational, outputs hazard).
REQ-022 All remaining logic SHALL reside in pipeline_controller.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- idex_memread=1, idex_rd=5, ifid_rs2=5, no redirect -> one cycle pc_enable=0, ifid_enable=0, idex_flush=1; stall_count=1.
- Same hazard with redirect=1 -> ifid_flush=1, idex_flush=1, pc_enable=1; stall_count unchanged.
- idex_rd=0, idex_memread=1, ifid_rs1=0 -> no stall.
- mem_req=1, mem_ready=0 for 3 cycles then 1 -> enables 0 for 3 cycles, all 1 on 4th, state RUN; stall_count=3.
- mem_req=1, mem_ready=0 held 15 cycles -> ERROR after 15th edge, mem_error=1, enables 0 until reset; reset -> all outputs 0, state RUN.
- Force CNT_W=4 with 20 stall cycles -> stall_count holds at 15.
